// File: rtl/rf_scoreboard_if.sv
// Decoder/register-file/writeback bundle for the dual-issue scoreboard.
// master = decoder + execution side, slave = register file.
interface rf_scoreboard_if #(
   parameter int REGNAME_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
);
   logic                     dec_valid;
   logic                     write1_en, write2_en;
   logic [REGNAME_WIDTH-1:0] write1_addr, write2_addr;
   logic                     read11_en, read12_en, read21_en, read22_en;
   logic [REGNAME_WIDTH-1:0] read11_addr, read12_addr, read21_addr, read22_addr;
   logic                     issue_stall;
   logic                     rd_valid;
   logic [DATA_WIDTH-1:0]    rd11_data, rd12_data, rd21_data, rd22_data;
   logic                     wb1_en, wb2_en;
   logic [REGNAME_WIDTH-1:0] wb1_addr, wb2_addr;
   logic [DATA_WIDTH-1:0]    wb1_data, wb2_data;
   logic                     wb_err;

   modport master (
      output dec_valid, write1_en, write2_en, write1_addr, write2_addr,
             read11_en, read12_en, read21_en, read22_en,
             read11_addr, read12_addr, read21_addr, read22_addr,
             wb1_en, wb2_en, wb1_addr, wb2_addr, wb1_data, wb2_data,
      input  issue_stall, rd_valid, rd11_data, rd12_data, rd21_data, rd22_data, wb_err
   );

   modport slave (
      input  dec_valid, write1_en, write2_en, write1_addr, write2_addr,
             read11_en, read12_en, read21_en, read22_en,
             read11_addr, read12_addr, read21_addr, read22_addr,
             wb1_en, wb2_en, wb1_addr, wb2_addr, wb1_data, wb2_data,
      output issue_stall, rd_valid, rd11_data, rd12_data, rd21_data, rd22_data, wb_err
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with pending-write scoreboard: stalls issue on RAW/WAW against
// in-flight writes, forwards same-cycle writebacks, returns operands one cycle later.
module rf_fwd #(
   parameter int RNW = 5,
   parameter int DW  = 32
) (
   input  logic           en,
   input  logic [RNW-1:0] addr,
   input  logic [DW-1:0]  reg_val,
   input  logic           pend,
   input  logic           wb1_en,
   input  logic [RNW-1:0] wb1_addr,
   input  logic [DW-1:0]  wb1_data,
   input  logic           wb2_en,
   input  logic [RNW-1:0] wb2_addr,
   input  logic [DW-1:0]  wb2_data,
   output logic [DW-1:0]  data,
   output logic           ok
);
   logic hit1, hit2;
   assign hit1 = wb1_en && (wb1_addr == addr) && (addr != '0);
   assign hit2 = wb2_en && (wb2_addr == addr) && (addr != '0);
   // wb2 wins when both ports land on the same register
   assign data = hit2 ? wb2_data : (hit1 ? wb1_data : reg_val);
   assign ok   = !en || !pend || hit1 || hit2;
endmodule

module rf_scoreboard #(
   parameter int REGNAME_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input logic               clk,
   input logic               rst_n,
   rf_scoreboard_if.slave    bus
);
   localparam int RNW      = REGNAME_WIDTH;
   localparam int DW       = DATA_WIDTH;
   localparam int NUM_REGS = 2**RNW;
   localparam int NRD      = 4;

   logic [NUM_REGS-1:0][DW-1:0] regs;
   logic [NUM_REGS-1:0]         pending, wb_hit, reserve;
   logic [NRD-1:0]              rd_en, src_ok;
   logic [NRD-1:0][RNW-1:0]     rd_addr;
   logic [NRD-1:0][DW-1:0]      fwd_data, rd_q;
   logic                        rd_vld, err_q;
   logic                        w1_blk, w2_blk, accept, wb_bad;

   assign rd_en   = {bus.read22_en, bus.read21_en, bus.read12_en, bus.read11_en};
   assign rd_addr = {bus.read22_addr, bus.read21_addr, bus.read12_addr, bus.read11_addr};

   for (genvar g = 0; g < NRD; g++) begin : g_src
      rf_fwd #(.RNW(RNW), .DW(DW)) u_fwd (
         .en(rd_en[g]), .addr(rd_addr[g]),
         .reg_val(regs[rd_addr[g]]), .pend(pending[rd_addr[g]]),
         .wb1_en(bus.wb1_en), .wb1_addr(bus.wb1_addr), .wb1_data(bus.wb1_data),
         .wb2_en(bus.wb2_en), .wb2_addr(bus.wb2_addr), .wb2_data(bus.wb2_data),
         .data(fwd_data[g]), .ok(src_ok[g])
      );
   end

   always_comb begin
      wb_hit = '0;
      for (int a = 1; a < NUM_REGS; a++)
         wb_hit[a] = (bus.wb1_en && bus.wb1_addr == RNW'(a)) ||
                     (bus.wb2_en && bus.wb2_addr == RNW'(a));
   end

   assign w1_blk = bus.write1_en && (bus.write1_addr != '0) &&
                   pending[bus.write1_addr] && !wb_hit[bus.write1_addr];
   assign w2_blk = bus.write2_en && (bus.write2_addr != '0) &&
                   pending[bus.write2_addr] && !wb_hit[bus.write2_addr];
   assign bus.issue_stall = bus.dec_valid && (!(&src_ok) || w1_blk || w2_blk);
   assign accept          = bus.dec_valid && !bus.issue_stall;

   always_comb begin
      reserve = '0;
      if (accept) begin
         if (bus.write1_en) reserve[bus.write1_addr] = 1'b1;
         if (bus.write2_en) reserve[bus.write2_addr] = 1'b1;
      end
      reserve[0] = 1'b0;
   end

   assign wb_bad = (bus.wb1_en && bus.wb1_addr != '0 && !pending[bus.wb1_addr]) ||
                   (bus.wb2_en && bus.wb2_addr != '0 && !pending[bus.wb2_addr]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs    <= '0;
         pending <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int a = 1; a < NUM_REGS; a++) begin
            if (bus.wb2_en && bus.wb2_addr == RNW'(a))      regs[a] <= bus.wb2_data;
            else if (bus.wb1_en && bus.wb1_addr == RNW'(a)) regs[a] <= bus.wb1_data;
         end
         // a new reservation overrides a same-cycle writeback clear
         pending <= (pending & ~wb_hit) | reserve;
         if (wb_bad) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld <= 1'b0;
         rd_q   <= '0;
      end else begin
         rd_vld <= accept;
         if (accept)
            for (int g = 0; g < NRD; g++) rd_q[g] <= rd_en[g] ? fwd_data[g] : '0;
      end
   end

   assign bus.rd_valid  = rd_vld;
   assign bus.rd11_data = rd_q[0];
   assign bus.rd12_data = rd_q[1];
   assign bus.rd21_data = rd_q[2];
   assign bus.rd22_data = rd_q[3];
   assign bus.wb_err    = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed scenarios plus randomized traffic against a behavioural scoreboard model.
module tb_rf_scoreboard;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rf_scoreboard_if #(.REGNAME_WIDTH(5), .DATA_WIDTH(32)) bus ();
   rf_scoreboard #(.REGNAME_WIDTH(5), .DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_err, m_rdv;
   logic [31:0] m_rd [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int a = 0; a < 32; a++) begin m_regs[a] = 0; m_pend[a] = 0; end
      m_err = 0; m_rdv = 0;
      for (int i = 0; i < 4; i++) m_rd[i] = 0;
   endtask

   function automatic bit rd_en(input int i);
      case (i) 0: return bus.read11_en; 1: return bus.read12_en;
               2: return bus.read21_en; default: return bus.read22_en; endcase
   endfunction
   function automatic int rd_addr(input int i);
      case (i) 0: return int'(bus.read11_addr); 1: return int'(bus.read12_addr);
               2: return int'(bus.read21_addr); default: return int'(bus.read22_addr); endcase
   endfunction
   function automatic bit hit(input int a);
      return a != 0 && ((bus.wb1_en && int'(bus.wb1_addr) == a) || (bus.wb2_en && int'(bus.wb2_addr) == a));
   endfunction
   function automatic logic [31:0] fwd(input int a);
      if (a != 0 && bus.wb2_en && int'(bus.wb2_addr) == a) return bus.wb2_data;
      if (a != 0 && bus.wb1_en && int'(bus.wb1_addr) == a) return bus.wb1_data;
      return m_regs[a];
   endfunction
   function automatic bit exp_stall();
      bit s = 0;
      if (!bus.dec_valid) return 0;
      for (int i = 0; i < 4; i++)
         if (rd_en(i) && m_pend[rd_addr(i)] && !hit(rd_addr(i))) s = 1;
      if (bus.write1_en && bus.write1_addr != 0 && m_pend[bus.write1_addr] && !hit(int'(bus.write1_addr))) s = 1;
      if (bus.write2_en && bus.write2_addr != 0 && m_pend[bus.write2_addr] && !hit(int'(bus.write2_addr))) s = 1;
      return s;
   endfunction

   // one compare point per cycle, then advance the model across the coming edge
   task automatic step();
      bit acc;
      @(negedge clk);
      chk("issue_stall", bus.issue_stall, exp_stall());
      chk("rd_valid", bus.rd_valid, m_rdv);
      chk("rd11", bus.rd11_data, m_rd[0]);
      chk("rd12", bus.rd12_data, m_rd[1]);
      chk("rd21", bus.rd21_data, m_rd[2]);
      chk("rd22", bus.rd22_data, m_rd[3]);
      chk("wb_err", bus.wb_err, m_err);
      if (rst_n) begin
         acc = bus.dec_valid && !exp_stall();
         m_rdv = acc;
         if (acc) for (int i = 0; i < 4; i++) m_rd[i] = rd_en(i) ? fwd(rd_addr(i)) : 0;
         if (bus.wb1_en && bus.wb1_addr != 0 && !m_pend[bus.wb1_addr]) m_err = 1;
         if (bus.wb2_en && bus.wb2_addr != 0 && !m_pend[bus.wb2_addr]) m_err = 1;
         if (bus.wb1_en && bus.wb1_addr != 0) begin m_regs[bus.wb1_addr] = bus.wb1_data; m_pend[bus.wb1_addr] = 0; end
         if (bus.wb2_en && bus.wb2_addr != 0) begin m_regs[bus.wb2_addr] = bus.wb2_data; m_pend[bus.wb2_addr] = 0; end
         if (acc && bus.write1_en && bus.write1_addr != 0) m_pend[bus.write1_addr] = 1;
         if (acc && bus.write2_en && bus.write2_addr != 0) m_pend[bus.write2_addr] = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.dec_valid = 0; bus.write1_en = 0; bus.write2_en = 0;
      bus.write1_addr = 0; bus.write2_addr = 0;
      bus.read11_en = 0; bus.read12_en = 0; bus.read21_en = 0; bus.read22_en = 0;
      bus.read11_addr = 0; bus.read12_addr = 0; bus.read21_addr = 0; bus.read22_addr = 0;
      bus.wb1_en = 0; bus.wb2_en = 0; bus.wb1_addr = 0; bus.wb2_addr = 0;
      bus.wb1_data = 0; bus.wb2_data = 0;
   endtask

   function automatic logic [4:0] pick_wb();
      int q[$];
      for (int a = 1; a < 32; a++) if (m_pend[a]) q.push_back(a);
      if (q.size() == 0 || $urandom_range(0, 19) == 0) return 5'($urandom_range(0, 31));
      return 5'(q[$urandom_range(0, q.size() - 1)]);
   endfunction

   initial begin
      clr(); rst_n = 0; m_reset();
      #1;
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_wb_err", bus.wb_err, 0);
      chk("rst_rd11", bus.rd11_data, 0);
      step(); step();
      rst_n = 1;
      step();

      // 1: r1 <- (r2, r3)
      bus.dec_valid = 1; bus.write1_en = 1; bus.write1_addr = 1;
      bus.read11_en = 1; bus.read11_addr = 2; bus.read12_en = 1; bus.read12_addr = 3;
      #1 chk("t1_stall", bus.issue_stall, 0);
      step();
      chk("t1_rd_valid", bus.rd_valid, 1);
      chk("t1_rd11", bus.rd11_data, 0);
      chk("t1_rd12", bus.rd12_data, 0);

      // 2: RAW on r1 holds until the writeback arrives
      clr(); bus.dec_valid = 1; bus.read11_en = 1; bus.read11_addr = 1;
      #1 chk("t2_stall", bus.issue_stall, 1);
      step();
      chk("t2_stall_held", bus.issue_stall, 1);
      chk("t2_rd_valid_low", bus.rd_valid, 0);
      bus.wb1_en = 1; bus.wb1_addr = 1; bus.wb1_data = 32'hDEAD_BEEF;
      #1 chk("t2_stall_released", bus.issue_stall, 0);
      step();
      chk("t2_rd11", bus.rd11_data, 32'hDEAD_BEEF);

      // 3: dual writeback to the same pending register
      clr(); bus.dec_valid = 1; bus.write1_en = 1; bus.write1_addr = 5; step();
      clr(); bus.wb1_en = 1; bus.wb1_addr = 5; bus.wb1_data = 32'h11;
      bus.wb2_en = 1; bus.wb2_addr = 5; bus.wb2_data = 32'h22; step();
      clr(); bus.dec_valid = 1; bus.read21_en = 1; bus.read21_addr = 5;
      #1 chk("t3_stall", bus.issue_stall, 0);
      step();
      chk("t3_rd21", bus.rd21_data, 32'h22);
      chk("t3_wb_err", bus.wb_err, 0);

      // 5: reservation beats same-cycle writeback
      clr(); bus.dec_valid = 1; bus.write2_en = 1; bus.write2_addr = 4; step();
      clr(); bus.dec_valid = 1; bus.write1_en = 1; bus.write1_addr = 4;
      bus.wb1_en = 1; bus.wb1_addr = 4; bus.wb1_data = 32'h9;
      #1 chk("t5_stall", bus.issue_stall, 0);
      step();
      clr(); bus.dec_valid = 1; bus.read22_en = 1; bus.read22_addr = 4;
      #1 chk("t5_r4_pending", bus.issue_stall, 1);
      step();
      clr(); bus.wb1_en = 1; bus.wb1_addr = 4; bus.wb1_data = 32'h33; step();
      chk("t5_wb_err", bus.wb_err, 0);

      // 6: r0 is never pending and always reads 0
      clr(); bus.dec_valid = 1; bus.write1_en = 1; bus.write1_addr = 0;
      bus.read11_en = 1; bus.read11_addr = 0; bus.wb1_en = 1; bus.wb1_addr = 0; bus.wb1_data = 32'hFF;
      #1 chk("t6_stall", bus.issue_stall, 0);
      step();
      chk("t6_rd11", bus.rd11_data, 0);
      clr(); bus.dec_valid = 1; bus.read12_en = 1; bus.read12_addr = 0; bus.write2_en = 1;
      #1 chk("t6_r0_not_pending", bus.issue_stall, 0);
      step();
      chk("t6_wb_err", bus.wb_err, 0);

      // 4: writeback to a non-pending register sets the sticky error
      clr(); bus.wb1_en = 1; bus.wb1_addr = 7; bus.wb1_data = 32'h5; step();
      chk("t4_wb_err", bus.wb_err, 1);
      clr(); bus.dec_valid = 1; bus.read11_en = 1; bus.read11_addr = 7;
      bus.write1_en = 1; bus.write1_addr = 9; step();
      chk("t4_rd11", bus.rd11_data, 32'h5);
      clr(); step(); step();
      chk("t4_wb_err_sticky", bus.wb_err, 1);

      // 7: async reset discards reservations (r9 pending here)
      clr(); bus.dec_valid = 1; bus.read11_en = 1; bus.read11_addr = 7; step();
      chk("t7_pre_rd11", bus.rd11_data, 32'h5);
      clr(); rst_n = 0; m_reset();
      #1;
      chk("t7_async_rd_valid", bus.rd_valid, 0);
      chk("t7_async_rd11", bus.rd11_data, 0);
      chk("t7_async_wb_err", bus.wb_err, 0);
      step();
      rst_n = 1;
      bus.dec_valid = 1; bus.read11_en = 1; bus.read11_addr = 9;
      #1 chk("t7_no_stall", bus.issue_stall, 0);
      step();
      chk("t7_rd11", bus.rd11_data, 0);

      // randomized traffic; writebacks mostly target pending registers
      for (int c = 0; c < 3000; c++) begin
         clr();
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 0; m_reset(); step(); rst_n = 1;
            continue;
         end
         bus.dec_valid   = ($urandom_range(0, 9) < 7);
         bus.write1_en   = $urandom_range(0, 1); bus.write1_addr = 5'($urandom_range(0, 11));
         bus.write2_en   = $urandom_range(0, 1); bus.write2_addr = 5'($urandom_range(0, 11));
         bus.read11_en   = $urandom_range(0, 1); bus.read11_addr = 5'($urandom_range(0, 11));
         bus.read12_en   = $urandom_range(0, 1); bus.read12_addr = 5'($urandom_range(0, 11));
         bus.read21_en   = $urandom_range(0, 1); bus.read21_addr = 5'($urandom_range(0, 11));
         bus.read22_en   = $urandom_range(0, 1); bus.read22_addr = 5'($urandom_range(0, 11));
         bus.wb1_en      = ($urandom_range(0, 9) < 5); bus.wb1_addr = pick_wb(); bus.wb1_data = $urandom;
         bus.wb2_en      = ($urandom_range(0, 9) < 4); bus.wb2_addr = pick_wb(); bus.wb2_data = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
